div_unit_param: RTL

//  Parametrised multi-cycle integer divider for the EX stage of the 5-stage pipeline.

---
 rtl/div_unit_param.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/div_unit_param.sv
// Multi-cycle restoring divider (signed/unsigned) retiring STEPS quotient bits per cycle,
// with valid/ready handshakes, flush, and defined divide-by-zero / overflow results.
module div_unit_param #(
    parameter int WIDTH = 32,
    parameter int STEPS = 1
) (
    input  logic             div_clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             div_valid,
    output logic             div_ready,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] r,
    output logic             div_by_zero,
    output logic             complete,
    input  logic             out_ready,
    output logic [1:0]       dbg_state_o
);

    // Handshake: a request transfers on an edge where div_valid & div_ready & ~flush;
    // a result transfers on an edge where complete & out_ready & ~flush.

    localparam int N  = WIDTH / STEPS;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_q;
    logic             q_sign_q;
    logic             r_sign_q;
    logic             dbz_q;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] r_q;

    logic [WIDTH-1:0] x_abs;
    logic [WIDTH-1:0] y_abs;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] dvd_step;
    logic             calc_last;

    // One restoring step: returns {remainder, dividend/quotient shift register}.
    function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                    input logic [WIDTH-1:0] dq,
                                                    input logic [WIDTH-1:0] dvs);
        logic [WIDTH:0] tmp;
        logic [WIDTH:0] diff;
        tmp  = {rem, dq[WIDTH-1]};
        diff = tmp - {1'b0, dvs};
        if (diff[WIDTH]) begin
            return {tmp[WIDTH-1:0], dq[WIDTH-2:0], 1'b0};
        end
        return {diff[WIDTH-1:0], dq[WIDTH-2:0], 1'b1};
    endfunction

    assign x_abs     = (div_signed && x[WIDTH-1]) ? -x : x;
    assign y_abs     = (div_signed && y[WIDTH-1]) ? -y : y;
    assign calc_last = (cnt_q == CW'(N - 1));

    always_comb begin
        rem_step = rem_q;
        dvd_step = dvd_q;
        for (int i = 0; i < STEPS; i++) begin
            {rem_step, dvd_step} = div_step(rem_step, dvd_step, dvs_q);
        end
    end

    always_ff @(posedge div_clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Divide-by-zero spends two cycles in FIX (cnt_q 0 then 1) so its result
    // appears two edges after accept.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (div_valid) state_d = (y == '0) ? FIX : CALC;
                CALC: if (calc_last) state_d = FIX;
                FIX:  if (!dbz_q || cnt_q != '0) state_d = DONE;
                DONE: if (out_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        div_ready   = (state_q == IDLE);
        complete    = (state_q == DONE);
        s           = complete ? s_q : '0;
        r           = complete ? r_q : '0;
        div_by_zero = complete & dbz_q;
        dbg_state_o = state_q;
    end

    always_ff @(posedge div_clk) begin
        if (!resetn) begin
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            q_sign_q <= 1'b0;
            r_sign_q <= 1'b0;
            dbz_q    <= 1'b0;
            s_q      <= '0;
            r_q      <= '0;
        end else if (flush) begin
            cnt_q <= '0;
            dbz_q <= 1'b0;
            s_q   <= '0;
            r_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (div_valid) begin
                        cnt_q    <= '0;
                        dbz_q    <= (y == '0);
                        q_sign_q <= div_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
                        r_sign_q <= div_signed & x[WIDTH-1];
                        // Zero divisor keeps the raw dividend for the remainder output.
                        dvd_q    <= (y == '0) ? x : x_abs;
                        dvs_q    <= y_abs;
                        rem_q    <= '0;
                    end
                end
                CALC: begin
                    dvd_q <= dvd_step;
                    rem_q <= rem_step;
                    cnt_q <= calc_last ? '0 : cnt_q + 1'b1;
                end
                FIX: begin
                    if (dbz_q) begin
                        s_q   <= '1;
                        r_q   <= dvd_q;
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        s_q <= q_sign_q ? -dvd_q : dvd_q;
                        r_q <= r_sign_q ? -rem_q : rem_q;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        cnt_q <= '0;
                        dbz_q <= 1'b0;
                        s_q   <= '0;
                        r_q   <= '0;
                    end
                end
                default: cnt_q <= '0;
            endcase
        end
    end

endmodule
